fetch_pc_unit: RTL and testbench

//  Program-counter stage directly upstream of the instruction memory: holds currPC, selects next PC
//  (sequential / branch / jump / jump-register) and drives currPC into the instruction memory.

---
 rtl/fetch_pc_unit_pkg.sv | 34 +++
 rtl/fetch_pc_unit_sat_counter32.sv | 47 ++++
 rtl/fetch_pc_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_pkg
//   Shared definitions for the fetch program-counter stage: the fetch state
//   encoding, the default memory map of the text segment, and a helper that
//   decides whether a byte address is a legal instruction fetch.
//   No ports (package).
// ---------------------------------------------------------------------------
package fetch_pc_unit_pkg;

  // Fetch-unit life cycle: one boot cycle, then running until a halt or a
  // fetch fault, both of which are terminal until reset.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetchState_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_TEXT_BASE  = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_TEXT_BYTES = 32'h0000_0404;

  // A fetch is legal when it is word aligned and lies between the text base
  // and the last full word of the segment. The comparison is plain unsigned,
  // so an address that wrapped past 2^32 lands below the base and fails.
  function automatic logic fetchAddrLegal(input logic [31:0] addr,
                                          input logic [31:0] textBase,
                                          input logic [31:0] textBytes);
    logic [31:0] lastWord;
    lastWord = textBase + textBytes - 32'd4;
    return (addr[1:0] == 2'b00) && (addr >= textBase) && (addr <= lastWord);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_sat_counter32.sv
// ---------------------------------------------------------------------------
// sat_counter32
//   32-bit up counter that sticks at all-ones instead of wrapping. A load
//   port allows presetting the value (tied off when used as a plain counter).
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   asynchronous active-high reset, clears the count
//     en_i        in   count up by one this cycle
//     load_i      in   overwrite the count with load_val_i (wins over en_i)
//     load_val_i  in   32-bit preset value
//     count_o     out  current count
// ---------------------------------------------------------------------------
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: a load takes precedence, otherwise increment unless the
  // counter already sits at its ceiling.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   Program-counter stage feeding the instruction memory. Holds the current
//   fetch address, picks the next one (sequential, branch, jump, jump
//   register), refuses illegal fetch targets by entering FAULT, and supports
//   stall and halt. Two saturating counters report RUN cycles and fetches.
//   Ports:
//     clk, rst          clock (rising edge) / async active-high reset
//     stall_i           hold currPC this cycle, redirects ignored
//     branch_taken_i    take branch, offset branch_imm_i (signed words)
//     jump_i            J/JAL redirect using jump_target_i
//     jump_reg_i        JR/JALR redirect to reg_target_i
//     halt_req_i        stop fetching, go to HALT
//     currPC_o          current fetch byte address
//     pc_plus4_o        currPC_o + 4
//     fetch_valid_o     currPC_o is a legal fetch this cycle (RUN)
//     halted_o/fault_o  unit is in HALT / FAULT
//     cycle_count_o     RUN cycles, saturating
//     fetch_count_o     advanced fetches, saturating
// ---------------------------------------------------------------------------
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] TEXT_BASE  = DEFAULT_TEXT_BASE,
  parameter logic [31:0] TEXT_BYTES = DEFAULT_TEXT_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_imm_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  input  logic        jump_reg_i,
  input  logic [31:0] reg_target_i,
  input  logic        halt_req_i,
  output logic [31:0] currPC_o,
  output logic [31:0] pc_plus4_o,
  output logic        fetch_valid_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] cycle_count_o,
  output logic [31:0] fetch_count_o
);

  fetchState_e state_q;
  fetchState_e state_d;
  logic [31:0] currPC_q;
  logic [31:0] currPC_d;
  logic [31:0] pcPlus4;
  logic [31:0] branchOffset;
  logic [31:0] nextPC;
  logic        nextLegal;
  logic        fetchAdvance;
  logic        cycleEn;

  assign pcPlus4      = currPC_q + 32'd4;
  assign branchOffset = {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};

  // Candidate next PC in redirect priority order; stall and halt are handled
  // in the state logic because they suppress the update altogether.
  always_comb begin
    nextPC = pcPlus4;
    if (jump_reg_i) begin
      nextPC = reg_target_i;
    end else if (jump_i) begin
      nextPC = {pcPlus4[31:28], jump_target_i, 2'b00};
    end else if (branch_taken_i) begin
      nextPC = pcPlus4 + branchOffset;
    end
  end

  assign nextLegal = fetchAddrLegal(nextPC, TEXT_BASE, TEXT_BYTES);

  // State and PC registers; reset discards whatever redirect was pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      currPC_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      currPC_q <= currPC_d;
    end
  end

  // Next state and next PC. Only a RUN cycle that is neither halting nor
  // stalled can move the PC, and only to a legal address; an illegal target
  // leaves the PC on the last good fetch and parks the unit in FAULT.
  always_comb begin
    state_d      = state_q;
    currPC_d     = currPC_q;
    fetchAdvance = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req_i) begin
          state_d = ST_HALT;
        end else if (!stall_i) begin
          if (nextLegal) begin
            currPC_d     = nextPC;
            fetchAdvance = 1'b1;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Status outputs decoded purely from the current state.
  always_comb begin
    fetch_valid_o = 1'b0;
    halted_o      = 1'b0;
    fault_o       = 1'b0;
    cycleEn       = 1'b0;
    case (state_q)
      ST_RUN: begin
        fetch_valid_o = 1'b1;
        cycleEn       = 1'b1;
      end
      ST_HALT:  halted_o = 1'b1;
      ST_FAULT: fault_o  = 1'b1;
      default: begin
        fetch_valid_o = 1'b0;
      end
    endcase
  end

  sat_counter32 u_cycleCounter (
    .clk        (clk),
    .rst        (rst),
    .en_i       (cycleEn),
    .load_i     (1'b0),
    .load_val_i (32'd0),
    .count_o    (cycle_count_o)
  );

  sat_counter32 u_fetchCounter (
    .clk        (clk),
    .rst        (rst),
    .en_i       (fetchAdvance),
    .load_i     (1'b0),
    .load_val_i (32'd0),
    .count_o    (fetch_count_o)
  );

  assign currPC_o   = currPC_q;
  assign pc_plus4_o = pcPlus4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
//   Directed scoreboard bench for fetch_pc_unit, plus a standalone
//   sat_counter32 used to exercise saturation from a preset value.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

  localparam logic [1:0] E_RUN   = 2'd1;
  localparam logic [1:0] E_HALT  = 2'd2;
  localparam logic [1:0] E_FAULT = 2'd3;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic        fault;
    logic [31:0] cyc;
    logic [31:0] fet;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [15:0] branchImm = 16'd0;
  logic        jump = 1'b0;
  logic [25:0] jumpTarget = 26'd0;
  logic        jumpReg = 1'b0;
  logic [31:0] regTarget = 32'd0;
  logic        haltReq = 1'b0;
  logic [31:0] currPC;
  logic [31:0] pcPlus4;
  logic        fetchValid;
  logic        halted;
  logic        fault;
  logic [31:0] cycleCount;
  logic [31:0] fetchCount;

  logic        satEn = 1'b0;
  logic        satLoad = 1'b0;
  logic [31:0] satLoadVal = 32'd0;
  logic [31:0] satCount;

  int          assertCount = 0;
  int          failCount = 0;
  logic [31:0] expCycle = 32'd0;
  logic [31:0] expFetch = 32'd0;
  expect_t     expQ[$];
  expect_t     monExp;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .branch_taken_i (branchTaken),
    .branch_imm_i   (branchImm),
    .jump_i         (jump),
    .jump_target_i  (jumpTarget),
    .jump_reg_i     (jumpReg),
    .reg_target_i   (regTarget),
    .halt_req_i     (haltReq),
    .currPC_o       (currPC),
    .pc_plus4_o     (pcPlus4),
    .fetch_valid_o  (fetchValid),
    .halted_o       (halted),
    .fault_o        (fault),
    .cycle_count_o  (cycleCount),
    .fetch_count_o  (fetchCount)
  );

  sat_counter32 u_sat (
    .clk        (clk),
    .rst        (rst),
    .en_i       (satEn),
    .load_i     (satLoad),
    .load_val_i (satLoadVal),
    .count_o    (satCount)
  );

  // One comparison: counts it and reports a mismatch on a single line.
  function automatic void checkField(input string tag, input string field,
                                     input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s.%s actual=0x%08h expected=0x%08h", tag, field, act, exp);
    end
  endfunction

  // Compare every DUT output against one scoreboard entry.
  function automatic void checkOutput(input expect_t e);
    checkField(e.tag, "currPC",     currPC,              e.pc);
    checkField(e.tag, "pcPlus4",    pcPlus4,             e.pc + 32'd4);
    checkField(e.tag, "fetchValid", {31'd0, fetchValid}, {31'd0, e.valid});
    checkField(e.tag, "halted",     {31'd0, halted},     {31'd0, e.halted});
    checkField(e.tag, "fault",      {31'd0, fault},      {31'd0, e.fault});
    checkField(e.tag, "cycleCount", cycleCount,          e.cyc);
    checkField(e.tag, "fetchCount", fetchCount,          e.fet);
  endfunction

  // Push what the outputs must show after the coming rising edge.
  function automatic void pushExpect(input string tag, input logic [31:0] pc,
                                     input logic [1:0] st);
    expect_t e;
    e.tag    = tag;
    e.pc     = pc;
    e.valid  = (st == E_RUN);
    e.halted = (st == E_HALT);
    e.fault  = (st == E_FAULT);
    e.cyc    = expCycle;
    e.fet    = expFetch;
    expQ.push_back(e);
  endfunction

  // Monitor: after every rising edge pop and compare the pending entry.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput(monExp);
    end
  end

  // Drive one cycle of inputs and queue the hand-computed result.
  task automatic applyStimulus(input string tag, input logic st, input logic br,
                               input logic [15:0] imm, input logic jp,
                               input logic [25:0] jt, input logic jr,
                               input logic [31:0] rt, input logic hl,
                               input logic [31:0] ePC, input logic [1:0] eSt,
                               input int cInc, input int fInc);
    @(negedge clk);
    stall       = st;
    branchTaken = br;
    branchImm   = imm;
    jump        = jp;
    jumpTarget  = jt;
    jumpReg     = jr;
    regTarget   = rt;
    haltReq     = hl;
    expCycle    = expCycle + 32'(cInc);
    expFetch    = expFetch + 32'(fInc);
    pushExpect(tag, ePC, eSt);
  endtask

  task automatic idleCycle(input string tag, input logic [31:0] ePC,
                           input logic [1:0] eSt, input int cInc, input int fInc);
    applyStimulus(tag, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0,
                  ePC, eSt, cInc, fInc);
  endtask

  // Assert reset between edges, check the immediate async effect, then
  // release and queue the BOOT cycle expectation.
  task automatic doReset(input string tag);
    expect_t e;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    e.tag = tag; e.pc = 32'h0040_0000; e.valid = 1'b0; e.halted = 1'b0;
    e.fault = 1'b0; e.cyc = 32'd0; e.fet = 32'd0;
    checkOutput(e);
    stall = 1'b0; branchTaken = 1'b0; branchImm = 16'd0; jump = 1'b0;
    jumpTarget = 26'd0; jumpReg = 1'b0; regTarget = 32'd0; haltReq = 1'b0;
    expCycle = 32'd0;
    expFetch = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    pushExpect({tag, "_boot"}, 32'h0040_0000, E_RUN);
  endtask

  initial begin
    $display("[TB] fetch_pc_unit bench start");

    // Free run, branches, jump, stall with held jump, misaligned JR fault.
    doReset("rstA");
    idleCycle("seq1", 32'h0040_0004, E_RUN, 1, 1);
    idleCycle("seq2", 32'h0040_0008, E_RUN, 1, 1);
    idleCycle("seq3", 32'h0040_000C, E_RUN, 1, 1);
    idleCycle("seq4", 32'h0040_0010, E_RUN, 1, 1);
    applyStimulus("brBack", 0, 1, 16'hFFFC, 0, 26'd0, 0, 32'd0, 0, 32'h0040_0004, E_RUN, 1, 1);
    applyStimulus("brFwdA", 0, 1, 16'h0002, 0, 26'd0, 0, 32'd0, 0, 32'h0040_0010, E_RUN, 1, 1);
    applyStimulus("brFwdB", 0, 1, 16'h0002, 0, 26'd0, 0, 32'd0, 0, 32'h0040_001C, E_RUN, 1, 1);
    idleCycle("seq5", 32'h0040_0020, E_RUN, 1, 1);
    applyStimulus("jumpSame", 0, 0, 16'd0, 1, 26'h010_0008, 0, 32'd0, 0, 32'h0040_0020, E_RUN, 1, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stallJump", 1, 0, 16'd0, 1, 26'h010_0010, 0, 32'd0, 0,
                    32'h0040_0020, E_RUN, 1, 0);
    end
    applyStimulus("jumpGo", 0, 0, 16'd0, 1, 26'h010_0010, 0, 32'd0, 0, 32'h0040_0040, E_RUN, 1, 1);
    applyStimulus("jrMisal", 0, 0, 16'd0, 0, 26'd0, 1, 32'h0040_0002, 0, 32'h0040_0040, E_FAULT, 1, 0);
    applyStimulus("faultHold", 0, 1, 16'h0002, 1, 26'h010_0000, 0, 32'd0, 0, 32'h0040_0040, E_FAULT, 0, 0);

    // Halt wins over stall and branch; HALT is terminal.
    doReset("rstB");
    idleCycle("seqB", 32'h0040_0004, E_RUN, 1, 1);
    applyStimulus("stallB", 1, 0, 16'd0, 0, 26'd0, 0, 32'd0, 0, 32'h0040_0004, E_RUN, 1, 0);
    applyStimulus("haltReq", 1, 1, 16'h0002, 0, 26'd0, 0, 32'd0, 1, 32'h0040_0004, E_HALT, 1, 0);
    applyStimulus("haltHold1", 0, 0, 16'd0, 1, 26'h010_0010, 0, 32'd0, 0, 32'h0040_0004, E_HALT, 0, 0);
    applyStimulus("haltHold2", 0, 0, 16'd0, 0, 26'd0, 1, 32'h0040_0100, 0, 32'h0040_0004, E_HALT, 0, 0);

    // Top of the text segment: last legal word, then sequential overrun.
    doReset("rstC");
    applyStimulus("jrLast", 0, 0, 16'd0, 0, 26'd0, 1, 32'h0040_03FC, 0, 32'h0040_03FC, E_RUN, 1, 1);
    idleCycle("seqLast", 32'h0040_0400, E_RUN, 1, 1);
    idleCycle("seqOver", 32'h0040_0400, E_FAULT, 1, 0);

    // Branch below the text base faults on the first advance.
    doReset("rstD");
    applyStimulus("brBelow", 0, 1, 16'hFFFD, 0, 26'd0, 0, 32'd0, 0, 32'h0040_0000, E_FAULT, 1, 0);

    // Async reset in the middle of a stalled cycle.
    doReset("rstE");
    idleCycle("seqE", 32'h0040_0004, E_RUN, 1, 1);
    applyStimulus("stallE", 1, 1, 16'h0004, 0, 26'd0, 0, 32'd0, 0, 32'h0040_0004, E_RUN, 1, 0);
    @(negedge clk);
    stall = 1'b1;
    doReset("rstMidStall");
    idleCycle("seqAfterRst", 32'h0040_0004, E_RUN, 1, 1);

    // Let the monitor drain; anything left over is a missed comparison.
    repeat (3) @(posedge clk);
    #2;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end

    // Saturation of the counter from a preset near the ceiling.
    @(negedge clk);
    satLoad = 1'b1; satLoadVal = 32'hFFFF_FFFD; satEn = 1'b0;
    @(negedge clk);
    checkField("sat", "load", satCount, 32'hFFFF_FFFD);
    satLoad = 1'b0; satEn = 1'b1;
    @(negedge clk);
    checkField("sat", "inc1", satCount, 32'hFFFF_FFFE);
    @(negedge clk);
    checkField("sat", "inc2", satCount, 32'hFFFF_FFFF);
    @(negedge clk);
    checkField("sat", "hold", satCount, 32'hFFFF_FFFF);
    satLoad = 1'b1; satLoadVal = 32'd7; satEn = 1'b0;
    @(negedge clk);
    satLoad = 1'b0;
    @(negedge clk);
    checkField("sat", "enOff", satCount, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
